// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM state encoding, parity selectors and width limits.
package uart_pkg;

  localparam int MAX_DATA_WIDTH = 9;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // ST_ prefix keeps the enum literals clear of the STOP2 configuration port.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5
  } tx_state_t;

endpackage

// File: rtl/uart_parity_gen.sv
// Combinational parity bit generator, shared by the TX engine and the RX checker.
module uart_parity_gen
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_type,
  output logic                  parity_bit
);

  // Even parity makes the total count of ones even; odd parity inverts that.
  assign parity_bit = (par_type == PAR_ODD) ? ~^data : ^data;

endmodule

// File: rtl/uart_tx_frame_engine.sv
// UART transmit engine: one-word holding buffer, frame FSM and registered serial output.
// Bit boundaries come from the external TICK strobe; frames may run back to back.
module uart_tx_frame_engine
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  TICK,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  output logic                  DATA_READY,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYPE,
  input  logic                  STOP2,
  output logic                  TX_OUT,
  output logic                  BUSY,
  output logic                  FRAME_DONE,
  output tx_state_t             STATE_DBG
);

  localparam int              CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  tx_state_t             state;
  tx_state_t             state_next;
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  hold_full;
  logic [DATA_WIDTH-1:0] shifter;
  logic [DATA_WIDTH-1:0] shifter_next;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  cfg_par_en;
  logic                  cfg_stop2;
  logic                  cfg_par_bit;
  logic                  par_bit;
  logic                  accept;
  logic                  load;
  logic                  shift_en;
  logic                  frame_end;
  logic                  tx_next;

  // Handshake: a word transfers on any rising edge where DATA_VALID && DATA_READY;
  // DATA_READY depends only on the buffer state, never on DATA_VALID, and a source
  // facing DATA_READY = 0 must hold P_DATA until the transfer happens.
  assign DATA_READY = !hold_full;
  assign accept     = DATA_VALID && !hold_full;

  uart_parity_gen #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity (
    .data       (hold_data),
    .par_type   (PAR_TYPE),
    .parity_bit (par_bit)
  );

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; every transition is gated by TICK.
  always_comb begin
    state_next = state;
    frame_end  = 1'b0;
    if (TICK) begin
      case (state)
        ST_IDLE:   if (hold_full) state_next = ST_START;
        ST_START:  state_next = ST_DATA;
        ST_DATA:   if (bit_cnt == LAST_BIT) state_next = cfg_par_en ? ST_PARITY : ST_STOP1;
        ST_PARITY: state_next = ST_STOP1;
        ST_STOP1: begin
          if (cfg_stop2) state_next = ST_STOP2;
          else           frame_end  = 1'b1;
        end
        ST_STOP2:  frame_end  = 1'b1;
        default:   state_next = ST_IDLE;
      endcase
      // A pending word chains straight into the next start bit.
      if (frame_end) state_next = hold_full ? ST_START : ST_IDLE;
    end
  end

  // Output/datapath control: the line value is decoded from the upcoming state so
  // that TX_OUT can be a plain flop updating on the same edge as the FSM.
  always_comb begin
    load         = TICK && hold_full && ((state == ST_IDLE) || frame_end);
    shift_en     = TICK && (state == ST_DATA);
    shifter_next = shifter;
    tx_next      = 1'b1;
    if (load) begin
      shifter_next = hold_data;
    end else if (shift_en) begin
      shifter_next = shifter >> 1;
    end
    case (state_next)
      ST_START:  tx_next = 1'b0;
      ST_DATA:   tx_next = shifter_next[0];
      ST_PARITY: tx_next = cfg_par_bit;
      default:   tx_next = 1'b1;
    endcase
  end

  // Holding buffer, shifter, bit counter, latched frame config and output flops.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hold_data   <= '0;
      hold_full   <= 1'b0;
      shifter     <= '0;
      bit_cnt     <= '0;
      cfg_par_en  <= 1'b0;
      cfg_stop2   <= 1'b0;
      cfg_par_bit <= 1'b0;
      TX_OUT      <= 1'b1;
      FRAME_DONE  <= 1'b0;
    end else begin
      // Accept wins over load so a same-cycle refill leaves the buffer full.
      if (accept) begin
        hold_data <= P_DATA;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end

      shifter <= shifter_next;

      if (load) begin
        cfg_par_en  <= PAR_EN;
        cfg_stop2   <= STOP2;
        cfg_par_bit <= par_bit;
      end

      if (TICK && (state == ST_START)) begin
        bit_cnt <= '0;
      end else if (shift_en && (bit_cnt != LAST_BIT)) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end

      TX_OUT     <= tx_next;
      FRAME_DONE <= frame_end;
    end
  end

  // BUSY covers the FRAME_DONE cycle so it spans the whole frame including its closing edge.
  assign BUSY      = (state != ST_IDLE) || FRAME_DONE;
  assign STATE_DBG = state;

endmodule

// File: tb/tb_uart_tx_frame_engine.sv
// Self-checking bench for uart_tx_frame_engine: 8-bit instance with a frame scoreboard
// plus a 5-bit instance for the narrow-width frame.
`timescale 1ns/1ps
module tb_uart_tx_frame_engine;
  import uart_pkg::*;

  localparam int W        = 8;
  localparam int TICK_DIV = 4;
  localparam int BUDGET   = 2000;

  // ---------------- clock / reset / tick ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  bit   tick_en = 1'b0;
  int   tick_cnt = 0;

  always #5 clk = ~clk;

  initial begin : tick_gen
    forever begin
      @(posedge clk);
      #1;
      if (tick_en) begin
        tick     = (tick_cnt == TICK_DIV - 1);
        tick_cnt = (tick_cnt + 1) % TICK_DIV;
      end else begin
        tick     = 1'b0;
        tick_cnt = 0;
      end
    end
  end

  // ---------------- DUT (8-bit) ----------------
  logic [W-1:0] p_data = '0;
  logic         data_valid = 1'b0;
  logic         data_ready;
  logic         par_en = 1'b0;
  logic         par_type = 1'b0;
  logic         stop2 = 1'b0;
  logic         tx_out;
  logic         busy;
  logic         frame_done;
  tx_state_t    state_dbg;

  uart_tx_frame_engine #(.DATA_WIDTH(W)) dut (
    .CLK        (clk),
    .RST        (rst),
    .TICK       (tick),
    .P_DATA     (p_data),
    .DATA_VALID (data_valid),
    .DATA_READY (data_ready),
    .PAR_EN     (par_en),
    .PAR_TYPE   (par_type),
    .STOP2      (stop2),
    .TX_OUT     (tx_out),
    .BUSY       (busy),
    .FRAME_DONE (frame_done),
    .STATE_DBG  (state_dbg)
  );

  // ---------------- DUT (5-bit) ----------------
  logic [4:0] p_data5 = '0;
  logic       valid5 = 1'b0;
  logic       ready5;
  logic       par_en5 = 1'b1;
  logic       par_type5 = 1'b1;
  logic       stop2_5 = 1'b0;
  logic       tx5;
  logic       busy5;
  logic       done5;
  tx_state_t  state5;

  uart_tx_frame_engine #(.DATA_WIDTH(5)) dut5 (
    .CLK        (clk),
    .RST        (rst),
    .TICK       (tick),
    .P_DATA     (p_data5),
    .DATA_VALID (valid5),
    .DATA_READY (ready5),
    .PAR_EN     (par_en5),
    .PAR_TYPE   (par_type5),
    .STOP2      (stop2_5),
    .TX_OUT     (tx5),
    .BUSY       (busy5),
    .FRAME_DONE (done5),
    .STATE_DBG  (state5)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [11:0] exp_q[$];
  int          exp_len_q[$];

  bit          in_frame = 1'b0;
  int          nbits = 0;
  int          cur_len = 0;
  logic [11:0] cur_bits = '0;
  logic [11:0] exp_frame;
  logic [11:0] last_frame = '0;
  int          last_len = 0;
  int          frames_seen = 0;
  int          idle_ticks = 0;
  int          last_gap = 0;
  int          done_cnt = 0;
  bit          expect_done = 1'b0;

  // Frame model: start, data LSB-first, optional parity, one or two stop bits.
  function automatic void build_frame(input logic [W-1:0] d, input logic pe, input logic pt,
                                      input logic s2, output logic [11:0] bits, output int len);
    bits = '0;
    len  = 0;
    bits[len] = 1'b0; len++;
    for (int i = 0; i < W; i++) begin
      bits[len] = d[i]; len++;
    end
    if (pe) begin
      bits[len] = (($countones(d) % 2) != 0) ^ pt; len++;
    end
    bits[len] = 1'b1; len++;
    if (s2) begin
      bits[len] = 1'b1; len++;
    end
  endfunction

  // Line monitor: samples TX_OUT on every TICK cycle, away from the clock edge.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst) begin
        in_frame    = 1'b0;
        nbits       = 0;
        expect_done = 1'b0;
      end else begin
        if (expect_done) begin
          total++;
          if (frame_done !== 1'b1) begin
            bad++;
            $display("FAIL frame_done_pulse: got %b want 1", frame_done);
          end
          expect_done = 1'b0;
        end
        if (frame_done === 1'b1) done_cnt++;
        if (tick) begin
          if (!in_frame) begin
            if (tx_out === 1'b0) begin
              last_gap   = idle_ticks;
              idle_ticks = 0;
              if (exp_len_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_frame: start bit seen, got 0 want 1 (nothing queued)");
              end else begin
                in_frame = 1'b1;
                nbits    = 1;
                cur_bits = '0;
                cur_len  = exp_len_q[0];
              end
            end else begin
              idle_ticks++;
            end
          end else begin
            cur_bits[nbits] = tx_out;
            nbits++;
            if (nbits == cur_len) begin
              exp_frame = exp_q.pop_front();
              cur_len   = exp_len_q.pop_front();
              total++;
              if (cur_bits !== exp_frame) begin
                bad++;
                $display("FAIL frame_bits: got %b want %b", cur_bits, exp_frame);
              end
              last_frame  = cur_bits;
              last_len    = nbits;
              frames_seen++;
              in_frame    = 1'b0;
              expect_done = 1'b1;
            end
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [W-1:0] d, input logic pe, input logic pt, input logic s2);
    int cyc;
    logic [11:0] bits;
    int len;
    @(negedge clk);
    p_data     = d;
    data_valid = 1'b1;
    par_en     = pe;
    par_type   = pt;
    stop2      = s2;
    cyc = 0;
    while (data_ready !== 1'b1 && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= BUDGET) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got ready=%b want 1", data_ready);
      data_valid = 1'b0;
      return;
    end
    build_frame(d, pe, pt, s2, bits, len);
    exp_q.push_back(bits);
    exp_len_q.push_back(len);
    @(negedge clk);
    data_valid = 1'b0;
    total++;
    if (data_ready !== 1'b0) begin
      bad++;
      $display("FAIL ready_after_accept: got %b want 0", data_ready);
    end
  endtask

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (cyc >= BUDGET) begin
      bad++;
      $display("FAIL drain_timeout: got pending=%0d busy=%b want 0 0", exp_q.size(), busy);
    end
    repeat (2) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if (tx_out !== 1'b1 || busy !== 1'b0 || data_ready !== 1'b1 || frame_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got tx=%b busy=%b ready=%b done=%b want 1 0 1 0",
               tx_out, busy, data_ready, frame_done);
    end
    total++;
    if (state_dbg !== ST_IDLE || tx5 !== 1'b1 || ready5 !== 1'b1) begin
      bad++;
      $display("FAIL reset_state: got state=%0d tx5=%b ready5=%b want 0 1 1",
               state_dbg, tx5, ready5);
    end
    rst = 1'b0;
    tick_en = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int d0, f0;
    d0 = done_cnt;
    f0 = frames_seen;
    send_word(8'hA5, 1'b0, 1'b0, 1'b0);
    wait_idle();
    total++;
    if (frames_seen - f0 != 1 || last_frame[9:0] !== 10'b1101001010 || last_len != 10) begin
      bad++;
      $display("FAIL basic_a5: got frames=%0d bits=%b len=%0d want 1 1101001010 10",
               frames_seen - f0, last_frame[9:0], last_len);
    end
    total++;
    if (done_cnt - d0 != 1) begin
      bad++;
      $display("FAIL basic_done_count: got %0d want 1", done_cnt - d0);
    end
  endtask

  task automatic test_parity();
    send_word(8'hA5, 1'b1, PAR_EVEN, 1'b0);
    wait_idle();
    total++;
    if (last_len != 11 || last_frame[9] !== 1'b0) begin
      bad++;
      $display("FAIL parity_even: got len=%0d par=%b want 11 0", last_len, last_frame[9]);
    end
    send_word(8'hA5, 1'b1, PAR_ODD, 1'b0);
    wait_idle();
    total++;
    if (last_len != 11 || last_frame[9] !== 1'b1) begin
      bad++;
      $display("FAIL parity_odd: got len=%0d par=%b want 11 1", last_len, last_frame[9]);
    end
    send_word(8'hA5, 1'b1, PAR_ODD, 1'b1);
    wait_idle();
    total++;
    if (last_len != 12 || last_frame[11:9] !== 3'b111) begin
      bad++;
      $display("FAIL parity_stop2: got len=%0d tail=%b want 12 111", last_len, last_frame[11:9]);
    end
  endtask

  task automatic test_back_to_back();
    int f0, drops, cyc;
    f0 = frames_seen;
    send_word(8'h00, 1'b0, 1'b0, 1'b0);
    send_word(8'hFF, 1'b0, 1'b0, 1'b0);
    drops = 0;
    cyc = 0;
    while (frames_seen < f0 + 2 && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      if (frames_seen < f0 + 2 && busy !== 1'b1) drops++;
    end
    total++;
    if (drops != 0 || cyc >= BUDGET) begin
      bad++;
      $display("FAIL b2b_busy: got low_cycles=%0d timeout=%0d want 0 0", drops, cyc >= BUDGET);
    end
    total++;
    if (last_gap != 0) begin
      bad++;
      $display("FAIL b2b_gap: got %0d idle ticks want 0", last_gap);
    end
    wait_idle();
  endtask

  task automatic test_backpressure();
    int f0, stall_bad, cyc;
    logic [11:0] bits;
    int len;
    tick_en = 1'b0;
    repeat (3) @(negedge clk);
    f0 = frames_seen;
    send_word(8'h3C, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    p_data     = 8'hC3;
    data_valid = 1'b1;
    stall_bad  = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (data_ready !== 1'b0 || busy !== 1'b0 || tx_out !== 1'b1) stall_bad++;
    end
    total++;
    if (stall_bad != 0) begin
      bad++;
      $display("FAIL bp_stall: got %0d bad cycles want 0", stall_bad);
    end
    build_frame(8'hC3, 1'b0, 1'b0, 1'b1, bits, len);
    exp_q.push_back(bits);
    exp_len_q.push_back(len);
    tick_en = 1'b1;
    cyc = 0;
    while (data_ready !== 1'b1 && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    data_valid = 1'b0;
    p_data     = 8'h55;
    total++;
    if (data_ready !== 1'b0 || cyc >= BUDGET) begin
      bad++;
      $display("FAIL bp_accept: got ready=%b timeout=%0d want 0 0", data_ready, cyc >= BUDGET);
    end
    wait_idle();
    total++;
    if (frames_seen - f0 != 2 || last_frame[8:1] !== 8'hC3) begin
      bad++;
      $display("FAIL bp_data: got frames=%0d data=%h want 2 c3", frames_seen - f0, last_frame[8:1]);
    end
  endtask

  task automatic test_reset_midframe();
    int line_low, busy_high;
    send_word(8'h00, 1'b1, 1'b0, 1'b1);
    send_word(8'h00, 1'b1, 1'b0, 1'b1);
    repeat (TICK_DIV * 3) @(negedge clk);
    total++;
    if (tx_out !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_precond: got tx=%b busy=%b want 0 1", tx_out, busy);
    end
    rst = 1'b1;
    #1;
    total++;
    if (tx_out !== 1'b1 || busy !== 1'b0 || data_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset_async: got tx=%b busy=%b ready=%b want 1 0 1",
               tx_out, busy, data_ready);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_len_q.delete();
    line_low  = 0;
    busy_high = 0;
    for (int i = 0; i < TICK_DIV * 20; i++) begin
      @(negedge clk);
      if (tx_out !== 1'b1) line_low++;
      if (busy !== 1'b0) busy_high++;
    end
    total++;
    if (line_low != 0 || busy_high != 0) begin
      bad++;
      $display("FAIL mid_discard: got low=%0d busy=%0d cycles want 0 0", line_low, busy_high);
    end
  endtask

  task automatic test_dw5();
    logic [7:0] bits5;
    logic [7:0] exp5;
    int n, cyc;
    logic par5;
    par5 = (($countones(5'h1B) % 2) != 0) ^ 1'b1;
    exp5 = {1'b1, par5, 5'h1B, 1'b0};
    bits5 = '0;
    @(negedge clk);
    p_data5 = 5'h1B;
    valid5  = 1'b1;
    @(negedge clk);
    valid5 = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(tick === 1'b1 && tx5 === 1'b0) && cyc < BUDGET);
    n = 1;
    while (n < 8 && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      if (tick) begin
        bits5[n] = tx5;
        n++;
      end
    end
    @(negedge clk);
    total++;
    if (bits5 !== exp5 || bits5 !== 8'b11110110 || cyc >= BUDGET) begin
      bad++;
      $display("FAIL dw5_bits: got %b want %b", bits5, exp5);
    end
    total++;
    if (done5 !== 1'b1) begin
      bad++;
      $display("FAIL dw5_done: got %b want 1", done5);
    end
    repeat (3) @(negedge clk);
    total++;
    if (busy5 !== 1'b0 || tx5 !== 1'b1) begin
      bad++;
      $display("FAIL dw5_idle: got busy=%b tx=%b want 0 1", busy5, tx5);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_backpressure();
    test_reset_midframe();
    test_dw5();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
